// File: rtl/out_change_capture_if.sv
// Record stream carrying one captured {value, timestamp} per accepted transfer.
// A record transfers on every rising edge where m_valid && m_ready; the master holds m_data/m_ts stable while m_valid=1 and m_ready=0, and never withdraws m_valid before the transfer.
interface out_change_capture_if #(
  parameter int WIDTH    = 8,
  parameter int TS_WIDTH = 16
);
  logic                m_valid;
  logic                m_ready;
  logic [WIDTH-1:0]    m_data;
  logic [TS_WIDTH-1:0] m_ts;

  modport master (output m_valid, m_data, m_ts, input m_ready);
  modport slave  (input m_valid, m_data, m_ts, output m_ready);
endinterface

// File: rtl/out_change_capture.sv
// Samples an observed bus every cycle and queues each value change as a
// {value, timestamp} record in a first-word-fall-through FIFO.
module out_change_capture #(
  parameter int WIDTH    = 8,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 16
) (
  input  logic                     ref_clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr_ovf,
  out_change_capture_if.master     m,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_WIDTH-1:0] ts;
  logic [WIDTH-1:0]    prev;
  logic                first;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [WIDTH-1:0]    data_mem [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem   [DEPTH];

  logic change;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign change = en & (first | (din != prev));
  assign pop    = m.m_valid & m.m_ready;
  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign push   = change & (~full | pop);
  assign drop   = change & full & ~pop;

  assign m.m_valid = ~empty;
  assign m.m_data  = empty ? '0 : data_mem[rd_ptr];
  assign m.m_ts    = empty ? '0 : ts_mem[rd_ptr];

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      ts    <= '0;
      prev  <= '0;
      first <= 1'b1;
    end else if (en) begin
      ts    <= ts + TS_WIDTH'(1);
      prev  <= din;
      first <= 1'b0;
    end else begin
      first <= 1'b1;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (rst_n && push) begin
      data_mem[wr_ptr] <= din;
      ts_mem[wr_ptr]   <= ts;
    end
  end

  // A drop in the clearing cycle counts as the first drop after the clear.
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= clr_ovf ? 8'd1 : ((drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1);
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_out_change_capture.sv
// Self-checking bench for out_change_capture: directed scenarios plus a
// randomized run against a record-queue reference model.
module tb_out_change_capture;
  localparam int W  = 8;
  localparam int T  = 16;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic          ref_clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  din;
  logic          clr_ovf;
  logic [LW-1:0] level;
  logic          ovf;
  logic [7:0]    drop_cnt;

  out_change_capture_if #(.WIDTH(W), .TS_WIDTH(T)) m_if ();

  out_change_capture #(.WIDTH(W), .TS_WIDTH(T), .DEPTH(D)) dut (
    .ref_clk  (ref_clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .clr_ovf  (clr_ovf),
    .m        (m_if),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 ref_clk = ~ref_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored records as {value, timestamp}.
  logic [W+T-1:0] mq[$];
  logic [W+T-1:0] exp_q[$];
  logic [W+T-1:0] got_q[$];
  logic [T-1:0]   ts_m;
  logic [W-1:0]   last_m;
  bit             fresh_m;
  bit             ovf_m;
  int             drops_m;

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    got_q.delete();
    ts_m = '0;
    last_m = '0;
    fresh_m = 1'b1;
    ovf_m = 1'b0;
    drops_m = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    din = '0;
    clr_ovf = 1'b0;
    m_if.m_ready = 1'b0;
    @(posedge ref_clk);
    @(negedge ref_clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Drives one cycle of inputs, logs DUT transfers, advances the model.
  task automatic cycle(input logic e, input logic [W-1:0] d, input logic r, input logic c);
    int pre;
    bit ev, pop, drop;
    logic [W+T-1:0] head;
    en = e;
    din = d;
    m_if.m_ready = r;
    clr_ovf = c;
    if (m_if.m_valid && r) got_q.push_back({m_if.m_data, m_if.m_ts});
    pre = mq.size();
    pop = (pre > 0) && r;
    if (pop) begin
      head = mq.pop_front();
      exp_q.push_back(head);
    end
    ev = e && (fresh_m || d != last_m);
    drop = 1'b0;
    if (ev) begin
      if (pre < D || pop) mq.push_back({d, ts_m});
      else drop = 1'b1;
    end
    if (e) begin
      fresh_m = 1'b0;
      last_m = d;
      ts_m = ts_m + 1'b1;
    end else begin
      fresh_m = 1'b1;
    end
    if (drop) begin
      ovf_m = 1'b1;
      drops_m = c ? 1 : ((drops_m >= 255) ? 255 : drops_m + 1);
    end else if (c) begin
      ovf_m = 1'b0;
      drops_m = 0;
    end
    @(posedge ref_clk);
    @(negedge ref_clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({m_if.m_valid, m_if.m_data, m_if.m_ts} !== {1'b0, {W{1'b0}}, {T{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_stream got=%h exp=0", {m_if.m_valid, m_if.m_data, m_if.m_ts});
    end
    n_cmp++;
    if ({level, ovf, drop_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_status got level=%0d ovf=%b drop=%0d exp all 0", level, ovf, drop_cnt);
    end
  endtask

  task automatic test_first_sample();
    int hi_cnt, hi_at;
    do_reset();
    hi_cnt = 0;
    hi_at = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      if (m_if.m_valid === 1'b1) begin
        hi_cnt++;
        if (hi_at < 0) hi_at = i;
      end
    end
    n_cmp++;
    if (hi_cnt !== 1 || hi_at !== 0) begin
      n_err++;
      $display("FAIL first_valid got cycles=%0d at=%0d exp cycles=1 at=0", hi_cnt, hi_at);
    end
    n_cmp++;
    if (got_q.size() !== 1 || got_q[0] !== {8'h00, 16'd0}) begin
      n_err++;
      $display("FAIL first_record got n=%0d rec0=%h exp n=1 rec0=000000", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 24'hxxxxxx);
    end
  endtask

  task automatic test_change_seq();
    logic [W+T-1:0] exp_rec;
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1'b1, W'((i < 16) ? i / 4 : 3), 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() !== 4 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL seq_count got n=%0d ovf=%b exp n=4 ovf=0", got_q.size(), ovf);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      exp_rec = {W'(i), T'(4 * i)};
      n_cmp++;
      if (got_q[i] !== exp_rec) begin
        n_err++;
        $display("FAIL seq_rec%0d got=%h exp=%h", i, got_q[i], exp_rec);
      end
    end
  endtask

  task automatic test_overflow_drain();
    int valid_cycles;
    logic [W+T-1:0] exp_rec;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2) ? 8'hAA : 8'h55, 1'b0, 1'b0);
    n_cmp++;
    if ({level, ovf, drop_cnt} !== {LW'(16), 1'b1, 8'd4}) begin
      n_err++;
      $display("FAIL ovf_status got level=%0d ovf=%b drop=%0d exp 16 1 4", level, ovf, drop_cnt);
    end
    n_cmp++;
    if ({m_if.m_data, m_if.m_ts} !== {8'h55, 16'd0}) begin
      n_err++;
      $display("FAIL ovf_head_hold got=%h exp=550000", {m_if.m_data, m_if.m_ts});
    end
    valid_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_if.m_valid === 1'b1) valid_cycles++;
      cycle(1'b0, 8'hAA, 1'b1, 1'b0);
    end
    n_cmp++;
    if (valid_cycles !== 16 || level !== '0 || got_q.size() !== 16) begin
      n_err++;
      $display("FAIL drain_b2b got valid=%0d level=%0d n=%0d exp 16 0 16",
               valid_cycles, level, got_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      exp_rec = {(i % 2) ? 8'hAA : 8'h55, T'(i)};
      n_cmp++;
      if (got_q[i] !== exp_rec) begin
        n_err++;
        $display("FAIL drain_rec%0d got=%h exp=%h", i, got_q[i], exp_rec);
      end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, W'(i + 1), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    n_cmp++;
    if ({level, ovf, drop_cnt} !== {LW'(16), 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL full_pp_status got level=%0d ovf=%b drop=%0d exp 16 0 0", level, ovf, drop_cnt);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'hEE, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() !== 17 || got_q[0] !== {8'h01, 16'd0} || got_q[got_q.size()-1] !== {8'hEE, 16'd16}) begin
      n_err++;
      $display("FAIL full_pp_order got n=%0d first=%h last=%h exp n=17 first=010000 last=ee0010",
               got_q.size(), got_q[0], got_q[got_q.size()-1]);
    end
  endtask

  task automatic test_wrap_and_rearm();
    do_reset();
    for (int i = 0; i < 65536; i++) cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle(1'b1, 8'h3D, 1'b1, 1'b0);
    cycle(1'b1, 8'h3D, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() !== 2 || got_q[1] !== {8'h3D, 16'd0}) begin
      n_err++;
      $display("FAIL ts_wrap got n=%0d rec=%h exp n=2 rec=3d0000", got_q.size(), got_q[got_q.size()-1]);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h3D, 1'b1, 1'b0);
    cycle(1'b1, 8'h3D, 1'b1, 1'b0);
    cycle(1'b0, 8'h3D, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() !== 3 || got_q[2] !== {8'h3D, 16'd2}) begin
      n_err++;
      $display("FAIL rearm got n=%0d rec=%h exp n=3 rec=3d0002", got_q.size(), got_q[got_q.size()-1]);
    end
  endtask

  task automatic test_reset_mid_and_clear();
    int n_before;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2) ? 8'hAA : 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (level !== LW'(8)) begin
      n_err++;
      $display("FAIL mid_level got=%0d exp=8", level);
    end
    rst_n = 1'b0;
    @(posedge ref_clk);
    @(negedge ref_clk);
    rst_n = 1'b1;
    model_clear();
    n_cmp++;
    if ({m_if.m_valid, level, ovf, drop_cnt} !== '0) begin
      n_err++;
      $display("FAIL mid_reset got valid=%b level=%0d ovf=%b drop=%0d exp all 0",
               m_if.m_valid, level, ovf, drop_cnt);
    end
    n_before = got_q.size();
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() !== n_before) begin
      n_err++;
      $display("FAIL mid_flush got extra=%0d exp=0", got_q.size() - n_before);
    end
    for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2) ? 8'hAA : 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    n_cmp++;
    if ({ovf, drop_cnt} !== {1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL clr_ovf got ovf=%b drop=%0d exp 0 0", ovf, drop_cnt);
    end
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    n_cmp++;
    if ({ovf, drop_cnt} !== {1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL clr_vs_drop got ovf=%b drop=%0d exp 1 1", ovf, drop_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 290; i++) cycle(1'b1, (i % 2) ? 8'h0F : 8'hF0, 1'b0, 1'b0);
    n_cmp++;
    if ({ovf, drop_cnt} !== {1'b1, 8'd255}) begin
      n_err++;
      $display("FAIL drop_sat got ovf=%b drop=%0d exp 1 255", ovf, drop_cnt);
    end
  endtask

  task automatic test_random();
    logic          e, r, c;
    logic [W-1:0]  d;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      n_cmp++;
      if ({m_if.m_valid, level, ovf, drop_cnt} !== {mq.size() > 0, LW'(mq.size()), ovf_m, 8'(drops_m)}) begin
        n_err++;
        $display("FAIL rnd_status cyc=%0d got v=%b l=%0d o=%b d=%0d exp v=%b l=%0d o=%b d=%0d", i,
                 m_if.m_valid, level, ovf, drop_cnt, mq.size() > 0, mq.size(), ovf_m, drops_m);
      end
      if (mq.size() > 0) begin
        n_cmp++;
        if ({m_if.m_data, m_if.m_ts} !== mq[0]) begin
          n_err++;
          $display("FAIL rnd_head cyc=%0d got=%h exp=%h", i, {m_if.m_data, m_if.m_ts}, mq[0]);
        end
      end
      e = ($urandom_range(0, 9) < 8);
      d = W'($urandom_range(0, 3));
      r = ($urandom_range(0, 9) < ((i / 200) % 2 ? 7 : 3));
      c = ($urandom_range(0, 19) == 0);
      cycle(e, d, r, c);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rnd_rec%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    din = '0;
    clr_ovf = 1'b0;
    m_if.m_ready = 1'b0;
    @(negedge ref_clk);
    test_reset();
    test_first_sample();
    test_change_seq();
    test_overflow_drain();
    test_full_push_pop();
    test_wrap_and_rearm();
    test_reset_mid_and_clear();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
